// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line-level constants used by
// both the transmit serializer and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   MIN_PRESCALE = 4;
  localparam logic START_BIT    = 1'b0;
  localparam logic STOP_BIT     = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-request / serial-line bundle for uart_tx_serializer; master drives requests,
// slave (the serializer) drives the line, busy flag and FSM state for observation.
interface uart_tx_if
  import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 5
) ();

    // Handshake: a request (data_valid_in=1) is taken on a rising clk edge only while
    // busy_out=0; while busy_out=1 requests are dropped, never queued.
    logic [PRESC_W-1:0] prescale_in;
    logic [DATA_W-1:0]  data_in;
    logic               data_valid_in;
    logic               par_en_in;
    logic               par_type_in;
    logic               tx_out;
    logic               busy_out;
    uart_state_e        state_dbg;

    modport master (
        output prescale_in, data_in, data_valid_in, par_en_in, par_type_in,
        input  tx_out, busy_out, state_dbg
    );

    modport slave (
        input  prescale_in, data_in, data_valid_in, par_en_in, par_type_in,
        output tx_out, busy_out, state_dbg
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter for the UART transmitter: counts 0..P-1 while running and
// pulses bit_done_out on the last clock of each bit, with P clamped to MIN_PRESCALE.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int PRESC_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_in,
    input  logic [PRESC_W-1:0] presc_in,
    output logic               bit_done_out
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic [PRESC_W-1:0] presc_eff;

    always_comb begin
        presc_eff    = (presc_in < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE) : presc_in;
        bit_done_out = run_in && (cnt_q == presc_eff - 1'b1);
        // Holding at zero while idle makes the first START clock count as 0.
        cnt_d        = (!run_in || bit_done_out) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_W bits LSB first, optional parity, one stop bit.
// Parity support is compiled only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 5
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam int BIT_W = $clog2(DATA_W);

    uart_state_e        state_q, state_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;
`else
    logic unused_par;
    assign unused_par = &{1'b0, bus.par_en_in, bus.par_type_in};
`endif

    uart_tx_bit_timer #(.PRESC_W(PRESC_W)) u_bit_timer (
        .clk          (clk),
        .reset        (reset),
        .run_in       (state_q != ST_IDLE),
        .presc_in     (presc_q),
        .bit_done_out (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        presc_d   = presc_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.data_valid_in) begin
                    shreg_d   = bus.data_in;
                    presc_d   = bus.prescale_in;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = bus.par_en_in;
                    par_bit_d = (^bus.data_in) ^ bus.par_type_in;
`endif
                    state_d   = ST_START;
                    tx_d      = START_BIT;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = STOP_BIT;
                        end
`else
                        state_d = ST_STOP;
                        tx_d    = STOP_BIT;
`endif
                    end else begin
                        // Shift and present the next bit in the same edge.
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = STOP_BIT;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = STOP_BIT;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            presc_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            presc_q   <= presc_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    assign bus.tx_out    = tx_q;
    assign bus.busy_out  = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer; frames are captured per clock
// and compared bit-by-bit against hand-written expected line patterns.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic line_s [0:511];

  uart_tx_if #(.DATA_W(8), .PRESC_W(5)) bus ();

  uart_tx_serializer #(.DATA_W(8), .PRESC_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents a request at a negedge; returns at the negedge after the accepting edge,
  // i.e. on clock 0 of the START bit. With hold=1 data_valid_in stays high.
  task automatic start_frame(input logic [7:0] d, input logic [4:0] presc,
                             input logic pe, input logic pt, input logic hold);
    @(negedge clk);
    bus.data_in       = d;
    bus.prescale_in   = presc;
    bus.par_en_in     = pe;
    bus.par_type_in   = pt;
    bus.data_valid_in = 1'b1;
    @(negedge clk);
    if (!hold) bus.data_valid_in = 1'b0;
  endtask

  // Samples the line each clock while busy, then checks start/middle/end of every bit
  // and the busy length. inject_at >= 0 pulses a 0x00 request at that frame clock.
  task automatic capture(input string tag, input logic [10:0] exp_bits, input int nbits,
                         input int p, input int inject_at);
    int cyc;
    logic [10:0] mid_v, first_v, last_v;
    cyc = 0;
    while (bus.busy_out === 1'b1 && cyc < 512) begin
      line_s[cyc] = bus.tx_out;
      if (cyc == inject_at) begin
        bus.data_in       = 8'h00;
        bus.data_valid_in = 1'b1;
      end else if (inject_at >= 0 && cyc == inject_at + 1) begin
        bus.data_valid_in = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    mid_v   = '0;
    first_v = '0;
    last_v  = '0;
    for (int k = 0; k < nbits; k++) begin
      first_v[k] = line_s[k*p];
      mid_v[k]   = line_s[k*p + p/2];
      last_v[k]  = line_s[k*p + p - 1];
    end
    check({tag, "_busy_len"}, 32'(cyc), 32'(nbits * p));
    check({tag, "_bits_first"}, 32'(first_v), 32'(exp_bits));
    check({tag, "_bits_mid"}, 32'(mid_v), 32'(exp_bits));
    check({tag, "_bits_last"}, 32'(last_v), 32'(exp_bits));
    check({tag, "_idle_line"}, 32'(bus.tx_out), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_seen;
    n_checks          = 0;
    n_errors          = 0;
    reset             = 1'b1;
    bus.data_in       = 8'h00;
    bus.prescale_in   = 5'd8;
    bus.data_valid_in = 1'b0;
    bus.par_en_in     = 1'b0;
    bus.par_type_in   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.tx_out), 32'(1));
    check("reset_busy", 32'(bus.busy_out), 32'(0));
    check("reset_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: P=8, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5, 5'd8, 1'b0, 1'b0, 1'b0);
    check("t1_state_start", 32'(bus.state_dbg), 32'(ST_START));
    capture("t1", 11'b01101001010, 10, 8, -1);

`ifdef UART_TX_PARITY_EN
    // 2: P=16, 0xA5 has four ones: even parity 0, odd parity 1
    start_frame(8'hA5, 5'd16, 1'b1, 1'b0, 1'b0);
    capture("t2_even", 11'b10101001010, 11, 16, -1);
    start_frame(8'hA5, 5'd16, 1'b1, 1'b1, 1'b0);
    capture("t2_odd", 11'b11101001010, 11, 16, -1);
`else
    // 2: parity inputs ignored in this build -> plain 10-bit frame
    start_frame(8'hA5, 5'd16, 1'b1, 1'b1, 1'b0);
    capture("t2_nopar", 11'b01101001010, 10, 16, -1);
`endif

    // 3: request mid-frame is dropped, not queued
    start_frame(8'h3C, 5'd8, 1'b0, 1'b0, 1'b0);
    capture("t3", 11'b01001111000, 10, 8, 20);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy_out === 1'b1) busy_seen++;
      @(negedge clk);
    end
    check("t3_not_queued", 32'(busy_seen), 32'(0));

    // 4: valid held high -> second start bit one clock after busy falls
    start_frame(8'h55, 5'd8, 1'b0, 1'b0, 1'b1);
    bus.data_in = 8'h3C;
    capture("t4a", 11'b01010101010, 10, 8, -1);
    @(negedge clk);
    bus.data_valid_in = 1'b0;
    check("t4_gap_start", 32'(bus.tx_out), 32'(0));
    capture("t4b", 11'b01001111000, 10, 8, -1);

    // 5: reset during data bit 3 (frame clocks 32..39)
    start_frame(8'hA5, 5'd8, 1'b0, 1'b0, 1'b0);
    repeat (34) @(negedge clk);
    check("t5_pre_state", 32'(bus.state_dbg), 32'(ST_DATA));
    check("t5_pre_tx", 32'(bus.tx_out), 32'(0));
    reset = 1'b1;
    #1;
    check("t5_rst_tx", 32'(bus.tx_out), 32'(1));
    check("t5_rst_busy", 32'(bus.busy_out), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    start_frame(8'hFF, 5'd8, 1'b0, 1'b0, 1'b0);
    capture("t5_ff", 11'b01111111110, 10, 8, -1);

    // 6: prescale clamp and maximum
    start_frame(8'h81, 5'd2, 1'b0, 1'b0, 1'b0);
    capture("t6_p2", 11'b01100000010, 10, 4, -1);
    start_frame(8'h81, 5'd31, 1'b0, 1'b0, 1'b0);
    capture("t6_p31", 11'b01100000010, 10, 31, -1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
